// File: rtl/dm_playback_ctrl.sv
// Playback sequencer for the 1-bit delta-modulation decoder.
// Buffers encode bytes in a 2-deep FIFO and serialises them at the sample rate.
module dm_playback_ctrl #(
  parameter int SAMPLE_DIV = 2268,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dec_encode,
  output logic       dec_start,
  output logic       dec_reset,
  output logic       busy,
  output logic [7:0] underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } state_e;

  localparam logic [15:0] DIV_MAX = 16'(SAMPLE_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  fifo0_q, fifo0_d;
  logic [7:0]  fifo1_q, fifo1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  left_q, left_d;
  logic [15:0] div_q, div_d;
  logic        enc_q, enc_d;
  logic        start_q, start_d;
  logic        drst_q, drst_d;
  logic [7:0]  urun_q, urun_d;

  logic       push;
  logic       pop;
  logic       tick;
  logic       leave;
  logic       cur_bit;
  logic [7:0] sh_next;

  assign in_ready     = (state_q != IDLE) && (cnt_q < 2'd2);
  assign busy         = (state_q != IDLE);
  assign dec_encode   = enc_q;
  assign dec_start    = start_q;
  assign dec_reset    = drst_q;
  assign underrun_cnt = urun_q;

  assign push  = in_valid && in_ready;
  assign pop   = (left_q == 4'd0) && (cnt_q != 2'd0);
  assign tick  = (state_q == RUN) && (div_q == DIV_MAX);
  assign leave = (state_q == RUN) && !enable;

  assign cur_bit = MSB_FIRST ? sh_q[7] : sh_q[0];
  assign sh_next = MSB_FIRST ? {sh_q[6:0], 1'b0}
                             : {1'b0, sh_q[7:1]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    cnt_d   = cnt_q;
    if (leave) begin
      cnt_d = 2'd0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          fifo0_d = in_data;
        end
        push && !pop: begin
          if (cnt_q == 2'd0) fifo0_d = in_data;
          else               fifo1_d = in_data;
          cnt_d = cnt_q + 2'd1;
        end
        !push && pop: begin
          fifo0_d = fifo1_q;
          cnt_d   = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // A tick with bits pending emits; a tick with nothing loaded is an underrun.
  always_comb begin
    sh_d    = sh_q;
    left_d  = left_q;
    enc_d   = enc_q;
    start_d = 1'b0;
    urun_d  = urun_q;
    if (leave) begin
      left_d = 4'd0;
    end else if (pop) begin
      sh_d   = fifo0_q;
      left_d = 4'd8;
      if (tick && urun_q != 8'hFF) urun_d = urun_q + 8'd1;
    end else if (tick) begin
      if (left_q != 4'd0) begin
        enc_d   = cur_bit;
        start_d = 1'b1;
        sh_d    = sh_next;
        left_d  = left_q - 4'd1;
      end else if (urun_q != 8'hFF) begin
        urun_d = urun_q + 8'd1;
      end
    end
    if ((state_q == IDLE && enable) || state_q == CLEAR)
      urun_d = 8'd0;
  end

  always_comb begin
    drst_d = (state_q == IDLE) && enable;
    div_d  = 16'd0;
    if (state_q == RUN && !leave)
      div_d = (div_q == DIV_MAX) ? 16'd0 : div_q + 16'd1;
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fifo0_q <= 8'd0;
      fifo1_q <= 8'd0;
      cnt_q   <= 2'd0;
      sh_q    <= 8'd0;
      left_q  <= 4'd0;
      div_q   <= 16'd0;
      enc_q   <= 1'b0;
      start_q <= 1'b0;
      drst_q  <= 1'b0;
      urun_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      fifo0_q <= fifo0_d;
      fifo1_q <= fifo1_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      left_q  <= left_d;
      div_q   <= div_d;
      enc_q   <= enc_d;
      start_q <= start_d;
      drst_q  <= drst_d;
      urun_q  <= urun_d;
    end
  end

endmodule

// File: tb/tb_dm_playback_ctrl.sv
// Bench for dm_playback_ctrl: MSB-first and LSB-first instances on shared
// stimulus, bit-level scoreboards, sample-rate spacing and underrun checks.
module tb_dm_playback_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] rdy;
  logic [1:0] enc;
  logic [1:0] st;
  logic [1:0] drst;
  logic [1:0] bsy;
  logic [7:0] urc [2];

  dm_playback_ctrl #(.SAMPLE_DIV(4), .MSB_FIRST(1'b1)) u_msb (
    .CLK100MHZ    (clk),
    .reset        (rst_n),
    .enable       (enable),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (rdy[0]),
    .dec_encode   (enc[0]),
    .dec_start    (st[0]),
    .dec_reset    (drst[0]),
    .busy         (bsy[0]),
    .underrun_cnt (urc[0])
  );

  dm_playback_ctrl #(.SAMPLE_DIV(4), .MSB_FIRST(1'b0)) u_lsb (
    .CLK100MHZ    (clk),
    .reset        (rst_n),
    .enable       (enable),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (rdy[1]),
    .dec_encode   (enc[1]),
    .dec_start    (st[1]),
    .dec_reset    (drst[1]),
    .busy         (bsy[1]),
    .underrun_cnt (urc[1])
  );

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int sc0 = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int rst_pulses = 0;
  int stall = 0;
  int acc = 0;
  logic q0 [$];
  logic q1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (drst[0]) begin
        rst_pulses++;
        acc = 0;
      end
      if (st[0]) begin
        if (q0.size() == 0) chk("strobe_unexp_msb", 1, 0);
        else chk("enc_msb", {31'd0, enc[0]}, {31'd0, q0.pop_front()});
        if (sc0 > 0) chk("spacing", {31'd0, (cyc - last_cyc) >= 4}, 1);
        if (sc0 == 0) first_cyc = cyc;
        last_cyc = cyc;
        sc0++;
        acc = enc[0] ? acc + 20 : acc - 20;
      end
      if (st[1]) begin
        if (q1.size() == 0) chk("strobe_unexp_lsb", 1, 0);
        else chk("enc_lsb", {31'd0, enc[1]}, {31'd0, q1.pop_front()});
      end
      if (rdy[0] != rdy[1]) chk("rdy_pair", {31'd0, rdy[1]}, {31'd0, rdy[0]});
      if (in_valid && rdy[0] && enable) begin
        for (int b = 0; b < 8; b++) begin
          q0.push_back(in_data[7-b]);
          q1.push_back(in_data[b]);
        end
      end
      if (in_valid && !rdy[0] && bsy[0]) stall++;
      if (!enable) begin
        q0.delete();
        q1.delete();
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic keep);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rdy[0]) ok = 1'b1;
    end
    chk("accept_timeout", {31'd0, ok}, 1);
    @(posedge clk);
    #1;
    in_valid = keep;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0) ok = 1'b1;
    end
    chk("drain_timeout", {31'd0, ok}, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {30'd0, bsy}, 0);
    chk("rst_ready", {30'd0, rdy}, 0);
    chk("rst_start", {30'd0, st}, 0);
    chk("rst_drst", {30'd0, drst}, 0);
    chk("rst_enc", {30'd0, enc}, 0);
    chk("rst_urc", {24'd0, urc[0]}, 0);
    rst_n = 1'b1;

    // Basic MSB-first byte
    @(posedge clk);
    #1;
    enable = 1'b1;
    sc0 = 0;
    send_byte(8'hA5, 1'b0);
    wait_drain();
    chk("a5_rst_pulses", rst_pulses, 1);
    chk("a5_strobes", sc0, 8);
    chk("a5_span", last_cyc - first_cyc, 28);
    chk("a5_acc", acc, 0);

    // Drop enable mid-byte
    sc0 = 0;
    send_byte(8'h3C, 1'b0);
    for (int i = 0; i < 200 && sc0 < 3; i++) @(negedge clk);
    chk("drop_strobes", sc0, 3);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_busy", {31'd0, bsy[0]}, 0);
    chk("drop_ready", {31'd0, rdy[0]}, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("drop_no_strobe", sc0, 3);
    chk("drop_no_drst", rst_pulses, 1);

    // Re-enable with 0xFF, then one underrun
    enable = 1'b1;
    sc0 = 0;
    send_byte(8'hFF, 1'b0);
    chk("reen_urc", {24'd0, urc[0]}, 0);
    chk("reen_rst_pulses", rst_pulses, 2);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("ff_strobes", sc0, 8);
    chk("ff_acc", acc, 160);
    chk("ff_urc", {24'd0, urc[0]}, 1);
    chk("ff_urc_lsb", {24'd0, urc[1]}, 1);

    // Back-to-back burst with backpressure
    stall = 0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h0F, 1'b0);
    chk("burst_stalled", {31'd0, stall > 0}, 1);
    wait_drain();
    chk("burst_q_lsb", q1.size(), 0);

    // Underrun saturation, then async reset mid-cycle
    repeat (1300) @(posedge clk);
    #1;
    chk("sat_urc", {24'd0, urc[0]}, 255);
    chk("sat_urc_lsb", {24'd0, urc[1]}, 255);
    chk("pre_rst_enc", {31'd0, enc[0]}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {30'd0, bsy}, 0);
    chk("arst_ready", {30'd0, rdy}, 0);
    chk("arst_enc", {30'd0, enc}, 0);
    chk("arst_start", {30'd0, st}, 0);
    chk("arst_drst", {30'd0, drst}, 0);
    chk("arst_urc", {24'd0, urc[0]}, 0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
